dmem_dma: RTL and testbench

- Word-copy engine that initiates accesses on the data-memory port: reads `count` words starting at `src_addr` and writes them starting at `dst_addr`.
- Sits beside the CPU datapath. The top level muxes the memory port to this block while `busy`=1; otherwise the CPU owns the port.
- Addresses are byte addresses. The memory is word-aligned and ignores `addr[1:0]`.
- The memory has a combinational read and writes on the clock edge.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_dma.sv | 109 ++++++++++
 tb/tb_dmem_dma.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory copy engine.
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } dma_state_t;

    localparam int unsigned WORD_BYTES      = 4;
    // Byte-offset bits cleared from latched addresses; memory is word-addressed.
    localparam int unsigned ADDR_ALIGN_MASK = 3;

endpackage

// File: rtl/dmem_dma.sv
// Word-copy engine: reads count_i words from src_addr_i and writes them to dst_addr_i
// over the shared data-memory port, one READ and one WRITE cycle per word.
module dmem_dma
    import dmem_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned R = 6
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [N-1:0] src_addr_i,
    input  logic [N-1:0] dst_addr_i,
    input  logic [R:0]   count_i,
    input  logic         hold_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] mem_addr_o,
    output logic [N-1:0] mem_writedata_o,
    output logic         mem_write_enable_o,
    input  logic [N-1:0] mem_readdata_i
);

    localparam logic [N-1:0] AlignKeep = ~N'(ADDR_ALIGN_MASK);
    localparam logic [N-1:0] PtrStep   = N'(WORD_BYTES);
    localparam logic [R:0]   RemOne    = (R+1)'(1);

    dma_state_t   state_q;
    logic [N-1:0] src_q;
    logic [N-1:0] dst_q;
    logic [N-1:0] buf_q;
    logic [R:0]   rem_q;
    logic         busy_q;
    logic         done_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        src_q <= src_addr_i & AlignKeep;
                        dst_q <= dst_addr_i & AlignKeep;
                        rem_q <= count_i;
                        if (count_i == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRead;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (!hold_i) begin
                        buf_q   <= mem_readdata_i;
                        src_q   <= src_q + PtrStep;
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    if (!hold_i) begin
                        dst_q <= dst_q + PtrStep;
                        rem_q <= rem_q - RemOne;
                        if (rem_q == RemOne) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

    always_comb begin
        mem_addr_o         = '0;
        mem_writedata_o    = '0;
        mem_write_enable_o = 1'b0;
        unique case (state_q)
            StRead: mem_addr_o = src_q;
            StWrite: begin
                mem_addr_o         = dst_q;
                mem_writedata_o    = buf_q;
                // A reset on this edge must not let the pending word commit.
                mem_write_enable_o = ~hold_i & ~reset_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_dma.sv
// Self-checking bench for dmem_dma: table of copies plus reset/restart corner sequences,
// with a write scoreboard fed from a shadow model of the data memory.
module tb_dmem_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [6:0]  count;
    logic        hold;
    logic        busy;
    logic        done;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wen;
    logic [15:0] mem_rdata;

    logic [15:0] mem [64];
    logic [15:0] shadow [64];
    logic        ld_en;
    logic [5:0]  ld_idx;
    logic [15:0] ld_data;

    logic [31:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_dma #(.N(16), .R(6)) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .start_i            (start),
        .src_addr_i         (src_addr),
        .dst_addr_i         (dst_addr),
        .count_i            (count),
        .hold_i             (hold),
        .busy_o             (busy),
        .done_o             (done),
        .mem_addr_o         (mem_addr),
        .mem_writedata_o    (mem_wdata),
        .mem_write_enable_o (mem_wen),
        .mem_readdata_i     (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr[7:2]] <= mem_wdata;
        else if (ld_en) mem[ld_idx] <= ld_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: every committed write must match the next expected {addr, data}.
    always @(posedge clk) begin
        if (mem_wen) begin
            if (exp_q.size() == 0) chk("unexpected_write", {mem_addr, mem_wdata}, 32'hxxxx_xxxx);
            else chk("write", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
    end

    task automatic run_copy(input string name, input logic [15:0] src, input logic [15:0] dst,
                            input logic [6:0] cnt, input logic [31:0] hmask,
                            input int exp_done, input int rc, input int poke);
        logic [15:0] sa, da, s, d;
        int busy_end, ncyc, diff;
        sa = src & 16'hFFFC;
        da = dst & 16'hFFFC;
        for (int k = 0; k < int'(cnt); k++) begin
            if (rc < 0 || 2 * k + 1 < rc) begin
                s = sa + 16'(4 * k);
                d = da + 16'(4 * k);
                exp_q.push_back({d, shadow[s[7:2]]});
                shadow[d[7:2]] = shadow[s[7:2]];
            end
        end
        @(negedge clk);
        start = 1'b1; src_addr = src; dst_addr = dst; count = cnt;
        @(posedge clk);
        #1 start = 1'b0;
        busy_end = (rc >= 0) ? rc + 1 : exp_done;
        ncyc     = ((rc >= 0) ? rc : exp_done) + 5;
        for (int i = 0; i < ncyc; i++) begin
            hold = (i < 32) ? hmask[i] : 1'b0;
            if (i == rc) reset = 1'b1;
            if (i == poke) begin
                start = 1'b1; src_addr = 16'h0010; dst_addr = 16'h00E0; count = 7'd5;
            end
            @(negedge clk);
            chk({name, "_busy"}, {31'd0, busy}, {31'd0, i < busy_end});
            chk({name, "_done"}, {31'd0, done}, {31'd0, i == exp_done});
            if (hold || i == exp_done) chk({name, "_wen_idle"}, {31'd0, mem_wen}, 32'd0);
            if (i == 0 && cnt != 0) chk({name, "_rd_addr"}, {16'd0, mem_addr}, {16'd0, sa});
            @(posedge clk);
            #1 reset = 1'b0; start = 1'b0; hold = 1'b0;
        end
        chk({name, "_pending"}, exp_q.size(), 32'd0);
        exp_q.delete();
        diff = 0;
        for (int w = 0; w < 64; w++) if (mem[w] !== shadow[w]) diff++;
        chk({name, "_mem"}, diff, 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [15:0] src;
        logic [15:0] dst;
        logic [6:0]  cnt;
        logic [31:0] hmask;
        int          exp_done;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"copy4",   16'h0000, 16'h0040, 7'd4, 32'h0,  8};
        vecs[1] = '{"count0",  16'h0010, 16'h0050, 7'd0, 32'h0,  0};
        vecs[2] = '{"hold3",   16'h0000, 16'h0060, 7'd3, 32'h46, 9};
        vecs[3] = '{"unalign", 16'h0005, 16'h0022, 7'd1, 32'h0,  2};
        vecs[4] = '{"wrap",    16'hFFF8, 16'h0080, 7'd3, 32'h0,  6};
        vecs[5] = '{"overlap", 16'h0000, 16'h0004, 7'd3, 32'h0,  6};

        reset = 1'b1; start = 1'b0; hold = 1'b0;
        src_addr = '0; dst_addr = '0; count = '0;
        ld_en = 1'b0; ld_idx = '0; ld_data = '0;

        for (int w = 0; w < 64; w++) begin
            shadow[w] = (w < 4) ? 16'h1111 * 16'(w + 1) : 16'hA000 + 16'(w);
            @(negedge clk);
            ld_en = 1'b1; ld_idx = 6'(w); ld_data = shadow[w];
        end
        @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);
        chk("rst_busy",  {31'd0, busy},    32'd0);
        chk("rst_done",  {31'd0, done},    32'd0);
        chk("rst_wen",   {31'd0, mem_wen}, 32'd0);
        chk("rst_addr",  {16'd0, mem_addr},  32'd0);
        chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++)
            run_copy(vecs[v].name, vecs[v].src, vecs[v].dst, vecs[v].cnt, vecs[v].hmask,
                     vecs[v].exp_done, -1, -1);

        // Start pulsed mid-copy with other addresses must be ignored.
        run_copy("busy_start", 16'h0000, 16'h00C0, 7'd2, 32'h0, 4, -1, 1);
        // Reset during the WRITE of word 2 (cycle 5): only words 0 and 1 land.
        run_copy("mid_reset", 16'h0000, 16'h00A0, 7'd4, 32'h0, -1, 5, -1);
        run_copy("after_reset", 16'h0020, 16'h0090, 7'd2, 32'h0, 4, -1, -1);
        // Full-depth copy smears word 0 upward through the whole memory.
        run_copy("full", 16'h0000, 16'h0104, 7'd64, 32'h0, 128, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
